// File: rtl/gated_sr_ff_bank.sv
// Bank of WIDTH gated SR flip-flops with selectable S=R=1 resolution, conflict flags and a saturating conflict counter.
// Optional registered q change mask when the SR_CHANGE_DET_EN macro is defined; otherwise changed is tied to 0.
module gated_sr_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter int               SR_MODE   = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conf_cnt,
  output logic [WIDTH-1:0] changed
);

  // Out-of-range modes fall back to hold.
  localparam int MODE = (SR_MODE >= 0 && SR_MODE <= 3) ? SR_MODE : 0;

  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] both_val;
  logic [WIDTH-1:0] q_next;

  assign hit = s & r;
  assign q_n = ~q;

  always_comb begin
    both_val = q;
    case (MODE)
      1:       both_val = '1;
      2:       both_val = '0;
      3:       both_val = ~q;
      default: both_val = q;
    endcase
  end

  always_comb begin
    q_next = q;
    if (en) begin
      q_next = (q & ~s & ~r) | (s & ~r) | (hit & both_val);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= RESET_VAL;
      conflict <= '0;
      conf_cnt <= '0;
    end else begin
      q        <= q_next;
      conflict <= en ? hit : '0;
      if (en && (|hit) && (conf_cnt != {CNT_W{1'b1}})) begin
        conf_cnt <= conf_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SR_CHANGE_DET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed <= '0;
    end else begin
      changed <= q_next ^ q;
    end
  end
`else
  assign changed = '0;
`endif

endmodule
